// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer, valid/ready on both sides.
// Words stream back to back: a held word moves into the shifter on the last-bit transfer.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_buf;
  logic             hold_full;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic [WIDTH-1:0] shifted;

  assign in_ready  = ~hold_full & ~rst;
  assign ser_valid = (state == SHIFT);
  assign ser_last  = (state == SHIFT) && (count == CNT_LAST);
  assign ser_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
  assign busy      = ser_valid | hold_full;

  assign accept    = in_valid & in_ready;
  assign xfer      = ser_valid & ser_ready;
  assign last_xfer = xfer & ser_last;

  // Shift toward the output end, zero fill.
  assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_buf  <= '0;
      hold_full <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= in_data;
            count     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            count <= '0;
            if (hold_full) begin
              shift_reg <= hold_buf;
              hold_full <= 1'b0;
            end else if (accept) begin
              shift_reg <= in_data;
            end else begin
              shift_reg <= '0;
              state     <= IDLE;
            end
          end else begin
            if (xfer) begin
              shift_reg <= shifted;
              count     <= count + CNT_W'(1);
            end
            // in_ready is low whenever hold_full is set, so this never overwrites
            if (accept) begin
              hold_buf  <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle vector table against an MSB-first
// instance, plus a hand-written LSB-first sequence on a second instance.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .ser_ready(ser_ready), .ser_last(ser_last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_ready(ser_ready), .ser_last(ser_last_l), .busy(busy_l)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] id;
    logic       rdy;
    logic       e_ir;
    logic       e_sv;
    logic       e_so;
    logic       e_sl;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic iv, input logic [3:0] id,
                              input logic rdy, input logic ir, input logic sv,
                              input logic so, input logic sl, input logic b);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.rdy = rdy;
    v.e_ir = ir; v.e_sv = sv; v.e_so = so; v.e_sl = sl; v.e_busy = b;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] id, input logic rdy);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = id; ser_ready = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; ser_ready = 1'b1;

    // rst iv id rdy | in_ready ser_valid ser_out ser_last busy
    // reset held with in_valid high
    add(1, 1, 4'hF, 1,  0, 0, 0, 0, 0);
    add(1, 1, 4'hF, 1,  0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    // single word 1011
    add(0, 1, 4'hB, 1,  1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    // backpressure on 1100 after first transfer
    add(0, 1, 4'hC, 1,  1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 0,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 0,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 0,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 1, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    // back-to-back A then 5 via hold buffer
    add(0, 1, 4'hA, 1,  1, 0, 0, 0, 0);
    add(0, 1, 4'h5, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    // 1001, then 0110 accepted directly on the last-bit edge
    add(0, 1, 4'h9, 1,  1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 1, 4'h6, 1,  1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 1, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    // reset mid-word: F shifting, 3 held
    add(0, 1, 4'hF, 1,  1, 0, 0, 0, 0);
    add(0, 1, 4'h3, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  0, 1, 1, 0, 1);
    add(1, 1, 4'h5, 1,  0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);
    add(0, 1, 4'h9, 1,  1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1,  1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1,  1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1,  1, 0, 0, 0, 0);

    // initial reset edge so registers leave X before the first checked row
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].rdy);
      check("in_ready",  i, in_ready_m,  vecs[i].e_ir);
      check("ser_valid", i, ser_valid_m, vecs[i].e_sv);
      check("ser_last",  i, ser_last_m,  vecs[i].e_sl);
      check("busy",      i, busy_m,      vecs[i].e_busy);
      if (vecs[i].e_sv)
        check("ser_out", i, ser_out_m, vecs[i].e_so);
    end

    // LSB-first: 0001 -> 1,0,0,0 on the second instance
    drive(0, 1, 4'b0001, 1);
    check("lsb_idle_valid", 0, ser_valid_l, 1'b0);
    check("lsb_idle_ready", 0, in_ready_l, 1'b1);
    begin
      logic [3:0] exp_bits;
      exp_bits = 4'b0001;
      for (int b = 0; b < 4; b++) begin
        drive(0, 0, 4'h0, 1);
        check("lsb_valid", b, ser_valid_l, 1'b1);
        check("lsb_out",   b, ser_out_l,   exp_bits[b]);
        check("lsb_last",  b, ser_last_l,  (b == 3) ? 1'b1 : 1'b0);
      end
    end
    drive(0, 0, 4'h0, 1);
    check("lsb_done_valid", 0, ser_valid_l, 1'b0);
    check("lsb_done_busy",  0, busy_l,      1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
